// File: rtl/ice40_spi_tx_fifo_feeder.sv
// Byte FIFO that feeds ice40_spi_master_controller via its start/data_out/busy handshake.
// Optional transfer counter enabled by defining ICE40_SPI_TX_FIFO_FEEDER_STATS_EN.
module ice40_spi_tx_fifo_feeder #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          ctrl_start,
    output logic [7:0]    ctrl_data_out,
    input  logic          ctrl_busy,
    output logic          idle
`ifdef ICE40_SPI_TX_FIFO_FEEDER_STATS_EN
    ,
    output logic [15:0]   sent_count
`endif
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          pop;
    logic          push;
    logic          done;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count_next;
    logic [7:0]    mem [DEPTH];

    // Writes see only the registered full flag, so a same-cycle pop never frees a slot early.
    assign push = wr_en && !full;
    assign done = (state == ST_WAIT_DONE) && !ctrl_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty && !ctrl_busy) begin
                    pop        = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ctrl_busy) begin
                    state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!ctrl_busy) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    // Storage array carries no reset; only pointers and occupancy define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            full          <= 1'b0;
            empty         <= 1'b1;
            overflow      <= 1'b0;
            idle          <= 1'b1;
            ctrl_start    <= 1'b0;
            ctrl_data_out <= 8'h00;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + PTR_ONE;
                ctrl_data_out <= mem[rd_ptr];
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            count      <= count_next;
            full       <= (count_next == CNT_FULL);
            empty      <= (count_next == '0);
            idle       <= (count_next == '0) && (state_next == ST_IDLE);
            ctrl_start <= (state_next == ST_ISSUE);
        end
    end

`ifdef ICE40_SPI_TX_FIFO_FEEDER_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sent_count <= 16'h0000;
        end else if (done) begin
            sent_count <= sent_count + 16'h0001;
        end
    end
`else
    logic unused_done;
    assign unused_done = done;
`endif

endmodule

// File: tb/tb_ice40_spi_tx_fifo_feeder.sv
// Scoreboard bench for ice40_spi_tx_fifo_feeder with a mock SPI controller.
module tb_ice40_spi_tx_fifo_feeder;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          ctrl_busy = 1'b1;
    logic          full, empty, overflow, ctrl_start, idle;
    logic [AW:0]   count;
    logic [7:0]    ctrl_data_out;
`ifdef ICE40_SPI_TX_FIFO_FEEDER_STATS_EN
    logic [15:0]   sent_count;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of bytes accepted but not yet issued, plus sticky overflow.
    logic [7:0]  q[$];
    bit          ovf_m = 1'b0;
    int          inflight = 0;
    int unsigned sent_m = 0;

    bit mock_en    = 1'b0;
    bit force_busy = 1'b1;
    int dly  = 2;
    int hold = 6;

    ice40_spi_tx_fifo_feeder #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .full          (full),
        .empty         (empty),
        .count         (count),
        .overflow      (overflow),
        .ctrl_start    (ctrl_start),
        .ctrl_data_out (ctrl_data_out),
        .ctrl_busy     (ctrl_busy),
        .idle          (idle)
`ifdef ICE40_SPI_TX_FIFO_FEEDER_STATS_EN
        ,
        .sent_count    (sent_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Mock controller: busy rises dly cycles after start is seen, stays high for hold cycles.
    initial begin : mock
        int d;
        int h;
        d = 0;
        h = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!mock_en) begin
                ctrl_busy = force_busy;
                d = 0;
                h = 0;
            end else if (ctrl_busy) begin
                if (h > 0) h--;
                if (h == 0) ctrl_busy = 1'b0;
            end else if (ctrl_start) begin
                d++;
                if (d >= dly) begin
                    ctrl_busy = 1'b1;
                    h = hold;
                    d = 0;
                end
            end else begin
                d = 0;
            end
        end
    end

    // Monitor: follows the handshake, pops expected bytes on each new issue, checks flags.
    initial begin : monitor
        logic       b;
        logic [7:0] held;
        logic [7:0] exp_b;
        held = 8'h00;
        forever begin
            @(posedge clk);
            b = ctrl_busy;
            #1;
            if (!reset) begin
                inflight = 0;
                sent_m   = 0;
                chk("rst_start", ctrl_start, 0);
                chk("rst_data", ctrl_data_out, 8'h00);
                chk("rst_count", count, 0);
                chk("rst_empty", empty, 1);
                chk("rst_full", full, 0);
                chk("rst_overflow", overflow, 0);
                chk("rst_idle", idle, 1);
`ifdef ICE40_SPI_TX_FIFO_FEEDER_STATS_EN
                chk("rst_sent", sent_count, 0);
`endif
                continue;
            end
            if (inflight == 2) begin
                if (!b) begin
                    inflight = 0;
                    sent_m++;
                end
                chk("wait_start_low", ctrl_start, 0);
            end else if (inflight == 1) begin
                if (b) begin
                    chk("start_fall", ctrl_start, 0);
                    inflight = 2;
                end else begin
                    chk("start_hold", ctrl_start, 1);
                    chk("data_hold", ctrl_data_out, held);
                end
            end else if (ctrl_start) begin
                chk("issue_busy_low", b, 0);
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL issue_unexpected got=%0h expected=none t=%0t", ctrl_data_out, $time);
                end else begin
                    exp_b = q.pop_front();
                    chk("issue_data", ctrl_data_out, exp_b);
                end
                held = ctrl_data_out;
                inflight = 1;
            end
            chk("count", count, q.size());
            chk("full", full, (q.size() == DEPTH));
            chk("empty", empty, (q.size() == 0));
            chk("overflow", overflow, ovf_m);
            chk("idle", idle, (q.size() == 0 && inflight == 0));
`ifdef ICE40_SPI_TX_FIFO_FEEDER_STATS_EN
            chk("sent_count", sent_count, sent_m & 32'hFFFF);
`endif
        end
    end

    // Called at a negedge; drives one write for the next edge and records the model outcome.
    task automatic put(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        if (q.size() < DEPTH) q.push_back(d);
        else ovf_m = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q.size() != 0 || inflight != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0 || inflight != 0) begin
            failures++;
            $display("FAIL drain_%s got=queued%0d/inflight%0d expected=0/0", tag, q.size(), inflight);
        end
        chk({tag, "_idle"}, idle, 1);
        chk({tag, "_count"}, count, 0);
    endtask

    initial begin : stim
        int n;
        // Reset with controller busy through its init sequence.
        reset = 1'b0;
        force_busy = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        put(8'hA5);
        repeat (9) begin
            chk("init_start_low", ctrl_start, 0);
            @(negedge clk);
        end
        force_busy = 1'b0;
        @(posedge clk);
        #1;
        chk("init_start_before", ctrl_start, 0);
        @(posedge clk);
        #1;
        chk("init_start_rise", ctrl_start, 1);
        chk("init_data", ctrl_data_out, 8'hA5);
        @(negedge clk);
        mock_en = 1'b1;
        drain("init");

        // Single byte latency.
        dly = 2;
        hold = 6;
        wr_en = 1'b1;
        wr_data = 8'h3C;
        q.push_back(8'h3C);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        chk("single_start_n", ctrl_start, 0);
        chk("single_count_n", count, 1);
        chk("single_empty_n", empty, 0);
        @(posedge clk);
        #1;
        chk("single_start_n1", ctrl_start, 1);
        chk("single_data", ctrl_data_out, 8'h3C);
        @(negedge clk);
        drain("single");

        // Ordering across pointer wrap, writing only while not full.
        dly = 1;
        hold = 2;
        for (int i = 0; i < 12; i++) begin
            n = 0;
            while (full && n < 100) begin
                @(negedge clk);
                n++;
            end
            put(i[7:0]);
        end
        drain("wrap");
        chk("wrap_overflow", overflow, 0);

        // Overflow while controller is held busy.
        mock_en = 1'b0;
        force_busy = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) put(8'h10 + i[7:0]);
        chk("ovf_full", full, 1);
        chk("ovf_not_yet", overflow, 0);
        put(8'h18);
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, DEPTH);
        mock_en = 1'b1;
        drain("ovf");
        chk("ovf_sticky", overflow, 1);

        // Push on the same edge as a pop with three bytes queued.
        mock_en = 1'b0;
        force_busy = 1'b1;
        repeat (2) @(negedge clk);
        put(8'h40);
        put(8'h41);
        put(8'h42);
        force_busy = 1'b0;
        @(negedge clk);
        put(8'h43);
        chk("pp_count", count, 3);
        chk("pp_start", ctrl_start, 1);
        mock_en = 1'b1;
        drain("pp");

        // Randomized traffic with a varying controller.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 31) == 0) begin
                dly  = $urandom_range(1, 3);
                hold = $urandom_range(1, 4);
            end
            if ($urandom_range(0, 99) < 40) put(8'($urandom));
            else @(negedge clk);
        end
        drain("rand");

        // Asynchronous reset while a byte is being issued with four more queued.
        mock_en = 1'b0;
        force_busy = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) put(8'h50 + i[7:0]);
        chk("rmid_count_before", count, 4);
        chk("rmid_start_before", ctrl_start, 1);
        ovf_m = 1'b1;
        put(8'h60);
        #2;
        reset = 1'b0;
        q.delete();
        ovf_m = 1'b0;
        #1;
        chk("rmid_start", ctrl_start, 0);
        chk("rmid_count", count, 0);
        chk("rmid_overflow", overflow, 0);
`ifdef ICE40_SPI_TX_FIFO_FEEDER_STATS_EN
        chk("rmid_sent", sent_count, 0);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Traffic resumes cleanly after reset.
        mock_en = 1'b1;
        dly = 1;
        hold = 3;
        put(8'h77);
        put(8'h88);
        drain("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
